// File: rtl/stream_resp_router_pkg.sv
// Shared width helpers and index type for the stream response router.
package stream_resp_router_pkg;

    function automatic int idx_width(input int n_inp);
        return (n_inp > 1) ? $clog2(n_inp) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_N_INP = 4;

    typedef logic [idx_width(DEF_N_INP)-1:0] idx_t;

endpackage

// File: rtl/stream_resp_router_idx_fifo.sv
// In-order FIFO of granted input indices; read data falls through from storage.
module stream_resp_router_idx_fifo
    import stream_resp_router_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign rdata_o = mem[rd_ptr];

    // Guarded here too so a careless caller can never corrupt the count.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    // DEPTH may be a non-power of two, so wrap by explicit compare.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stream_resp_router.sv
// Forwards arbitrated requests to one slave and routes in-order responses back to the issuing input.
module stream_resp_router
    import stream_resp_router_pkg::*;
#(
    parameter int REQ_W = 32,
    parameter int RSP_W = 32,
    parameter int N_INP = 4,
    parameter int DEPTH = 4,
    parameter int IDX_W = idx_width(N_INP),
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REQ_W-1:0] req_data_i,
    input  logic [IDX_W-1:0] req_idx_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    output logic [REQ_W-1:0] oup_data_o,
    output logic             oup_valid_o,
    input  logic             oup_ready_i,
    input  logic [RSP_W-1:0] rsp_data_i,
    input  logic             rsp_valid_i,
    output logic             rsp_ready_o,
    output logic [RSP_W-1:0] rsp_data_o,
    output logic [N_INP-1:0] rsp_valid_o,
    input  logic [N_INP-1:0] rsp_ready_i,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             err_o
);
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head;
    logic [N_INP-1:0] head_hit;

    // Handshakes: a beat transfers on a rising edge where valid & ready are both 1.
    // Valids never depend on the matching ready; ready may depend on valid-free state only.
    assign oup_valid_o = req_valid_i & ~full;
    assign req_ready_o = oup_ready_i & ~full;
    assign oup_data_o  = req_data_i;
    assign push        = req_valid_i & req_ready_o;

    stream_resp_router_idx_fifo #(
        .W     (IDX_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (req_idx_i),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (outstanding_o),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        head_hit = '0;
        for (int i = 0; i < N_INP; i++) begin
            head_hit[i] = (head == IDX_W'(i));
        end
    end

    // Empty never bypasses, so a response in the cycle of the first push waits.
    assign rsp_valid_o = (rsp_valid_i & ~empty) ? head_hit : '0;
    assign rsp_ready_o = ~empty & |(head_hit & rsp_ready_i);
    assign rsp_data_o  = rsp_data_i;
    assign pop         = rsp_valid_i & rsp_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (rsp_valid_i & empty) begin
            err_o <= 1'b1;
        end
    end

endmodule
